mw_countdown_timer: RTL and testbench
=====================================

# mw_countdown_timer

- BCD countdown timer for the microwave controller.
- Collects keypad digits into an M:SS time and counts it down on a 1 Hz tick. It handles start/pause/clear and the door interlock.
- Drives the 4-bit BCD digits `sec_on` (seconds ones), `sec_t` (seconds tens) and `min` (minutes) directly into the 7-segment decoder stage. It also signals cooking and completion to the magnetron/beeper logic.

## Interface
Parameters:
- `BEEP_TICKS`, default 3: number of `tick_1hz` pulses the `beep` output stays high in DONE (1..15).

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle enable pulse, once per second.
- `key_valid`  in  1  one-cycle strobe: `key_digit` holds a new keypress.
- `key_digit`  in  4  keypad value, 0-9 valid; 10-15 ignored.
- `start`  in  1  one-cycle start/resume strobe.
- `stop_clear`  in  1  one-cycle pause/clear strobe.
- `door_closed`  in  1  level, 1 = door shut.
- `sec_on`  out  4  BCD seconds ones.
- `sec_t`  out  4  BCD seconds tens.
- `min`  out  4  BCD minutes.
- `running`  out  1  high in RUN (magnetron enable).
- `done`  out  1  one-cycle pulse on reaching 0:00.
- `beep`  out  1  high while in DONE.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE. All outputs are registered.
- **Reset values:** IDLE, all digits 0, `running` = `done` = `beep` = 0, beep counter 0.
- **IDLE:**
  - `key_valid` with digit ≤9 shifts left: `min`←`sec_t`, `sec_t`←`sec_on`, `sec_on`←`key_digit`. Digit >9: no change.
  - `stop_clear`: all digits → 0.
  - `start` & `door_closed` & time≠0:00 → RUN. On entry the time is normalized: if `sec_t`≥6, then `sec_t`−=6 and `min`+=1; if `min` was 9, the time saturates to 9:59.
  - `start` with door open: ignored.
- **RUN:**
  - Each `tick_1hz` decrements the time in BCD. `sec_on` 0→9 borrows from `sec_t`; `sec_t` 0→5 borrows from `min`.
  - Tick at 0:01: digits → 0:00, state → DONE.
  - `door_closed`=0 or `stop_clear` → PAUSE, digits held. Keys ignored.
- **PAUSE:**
  - `start` & `door_closed` → RUN.
  - `stop_clear` → IDLE with digits cleared.
  - Keys and ticks ignored.
- **DONE:**
  - `beep`=1. Each tick increments the beep counter; on reaching `BEEP_TICKS`, go to IDLE.
  - `stop_clear` or `key_valid` → IDLE immediately, beep counter cleared. A key arriving this way is not shifted in.
  - Digits stay 0:00.
- **Priority within a cycle:** `rst` > `stop_clear` > door open > `start` > `key_valid` > `tick_1hz`.

## Timing
- Digit update is visible the cycle after the qualifying `tick_1hz` or `key_valid` edge.
- IDLE→RUN: `running` rises one cycle after `start`. A tick in the same cycle as `start` does not decrement.
- Door opens in RUN: `running` falls the next cycle. A tick in that same cycle is discarded.
- `done`: high for exactly one cycle, the first DONE cycle, aligned with digits first showing 0:00; `beep` rises the same cycle.
- Reset mid-RUN: next cycle is IDLE at 0:00 with all outputs low. No `done` pulse.
- Decrement never underflows: RUN is never entered or held at 0:00.

## Configuration
- `MW_QUICK_START_EN`, when defined:
  - `start` in IDLE with time 0:00 (door closed) loads 0:30 and enters RUN.
  - `start` in RUN adds 30 s: `sec_t`+3; if ≥6, subtract 6 and carry to `min`. Saturates at 9:59.
- Undefined: both cases are ignored (no state or digit change).

## Test plan
- **Entry and countdown:** keys 1,3,0, `start`, 11 ticks → 1:30 shown, `running`=1, then 1:19. Digit sequence 1:30→1:29…1:20→1:19.
- **Normalize and finish:** key 7,5 (0:75), `start` → 1:15. 75 ticks → 0:00, `done` one-cycle pulse, `beep` high 3 ticks, then IDLE.
- **Door interlock:** in RUN at 0:42, drop `door_closed` in a tick cycle → PAUSE at 0:42, `running`=0. Close the door + `start` → resumes from 0:42.
- **Clear path:** `stop_clear` in RUN → PAUSE. Second `stop_clear` → IDLE 0:00. `key_digit`=12 in IDLE → no change.
- **Reset mid-RUN at 3:07:** `rst` → 0:00, all outputs 0 next cycle, no `done`.
- **With `MW_QUICK_START_EN`:** `start` at 0:00 → 0:30 RUN. `start` at 9:45 → 9:59. `start` at 0:45 → 1:15. Without the macro, the same stimulus leaves state and digits unchanged.

Source files
------------

// File: rtl/mw_countdown_timer.sv
// rtl/mw_countdown_timer.sv - BCD M:SS microwave countdown timer with keypad entry, start/pause/clear and door interlock
// Optional feature macro: MW_QUICK_START_EN (start at 0:00 loads 0:30; start while running adds 30 s)
module mw_countdown_timer #(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] sec_on,
  output logic [3:0] sec_t,
  output logic [3:0] min,
  output logic       running,
  output logic       done,
  output logic       beep
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BEEP_LIMIT = 4'(BEEP_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] sec_on_nxt;
  logic [3:0] sec_t_nxt;
  logic [3:0] min_nxt;
  logic [3:0] beep_cnt;
  logic [3:0] beep_cnt_nxt;

  logic       time_zero;
  logic       time_one;
  logic [3:0] norm_sec_on;
  logic [3:0] norm_sec_t;
  logic [3:0] norm_min;
  logic [3:0] dec_sec_on;
  logic [3:0] dec_sec_t;
  logic [3:0] dec_min;

  assign time_zero = (min == 4'd0) && (sec_t == 4'd0) && (sec_on == 4'd0);
  assign time_one  = (min == 4'd0) && (sec_t == 4'd0) && (sec_on == 4'd1);

  // Normalize keyed-in time (seconds tens may be 6..9) into a legal M:SS, saturating at 9:59
  always_comb begin
    norm_sec_on = sec_on;
    norm_sec_t  = sec_t;
    norm_min    = min;
    if (sec_t >= 4'd6) begin
      if (min == 4'd9) begin
        norm_min    = 4'd9;
        norm_sec_t  = 4'd5;
        norm_sec_on = 4'd9;
      end else begin
        norm_sec_t = sec_t - 4'd6;
        norm_min   = min + 4'd1;
      end
    end
  end

  // One-second BCD decrement with borrow chain; only used when time is above 0:01
  always_comb begin
    dec_sec_on = sec_on - 4'd1;
    dec_sec_t  = sec_t;
    dec_min    = min;
    if (sec_on == 4'd0) begin
      dec_sec_on = 4'd9;
      if (sec_t == 4'd0) begin
        dec_sec_t = 4'd5;
        dec_min   = min - 4'd1;
      end else begin
        dec_sec_t = sec_t - 4'd1;
      end
    end
  end

`ifdef MW_QUICK_START_EN
  logic [3:0] add_sum;
  logic [3:0] add_sec_on;
  logic [3:0] add_sec_t;
  logic [3:0] add_min;

  // Add 30 s to a running (already normalized) time, saturating at 9:59
  always_comb begin
    add_sum    = sec_t + 4'd3;
    add_sec_on = sec_on;
    add_sec_t  = add_sum;
    add_min    = min;
    if (add_sum >= 4'd6) begin
      if (min == 4'd9) begin
        add_min    = 4'd9;
        add_sec_t  = 4'd5;
        add_sec_on = 4'd9;
      end else begin
        add_sec_t = add_sum - 4'd6;
        add_min   = min + 4'd1;
      end
    end
  end
`endif

  // Next-state and next-digit selection, honouring stop_clear > door > start > key > tick
  always_comb begin
    state_nxt    = state;
    sec_on_nxt   = sec_on;
    sec_t_nxt    = sec_t;
    min_nxt      = min;
    beep_cnt_nxt = beep_cnt;
    unique case (state)
      S_IDLE: begin
        if (stop_clear) begin
          sec_on_nxt = 4'd0;
          sec_t_nxt  = 4'd0;
          min_nxt    = 4'd0;
        end else if (start && door_closed && !time_zero) begin
          state_nxt  = S_RUN;
          sec_on_nxt = norm_sec_on;
          sec_t_nxt  = norm_sec_t;
          min_nxt    = norm_min;
`ifdef MW_QUICK_START_EN
        end else if (start && door_closed) begin
          state_nxt  = S_RUN;
          sec_on_nxt = 4'd0;
          sec_t_nxt  = 4'd3;
          min_nxt    = 4'd0;
`endif
        end else if (key_valid && (key_digit <= 4'd9)) begin
          min_nxt    = sec_t;
          sec_t_nxt  = sec_on;
          sec_on_nxt = key_digit;
        end
      end
      S_RUN: begin
        if (stop_clear || !door_closed) begin
          state_nxt = S_PAUSE;
`ifdef MW_QUICK_START_EN
        end else if (start) begin
          sec_on_nxt = add_sec_on;
          sec_t_nxt  = add_sec_t;
          min_nxt    = add_min;
`endif
        end else if (tick_1hz) begin
          if (time_one) begin
            state_nxt    = S_DONE;
            sec_on_nxt   = 4'd0;
            beep_cnt_nxt = 4'd0;
          end else begin
            sec_on_nxt = dec_sec_on;
            sec_t_nxt  = dec_sec_t;
            min_nxt    = dec_min;
          end
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          state_nxt  = S_IDLE;
          sec_on_nxt = 4'd0;
          sec_t_nxt  = 4'd0;
          min_nxt    = 4'd0;
        end else if (start && door_closed) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (stop_clear || key_valid) begin
          state_nxt    = S_IDLE;
          beep_cnt_nxt = 4'd0;
        end else if (tick_1hz) begin
          if ((beep_cnt + 4'd1) >= BEEP_LIMIT) begin
            state_nxt    = S_IDLE;
            beep_cnt_nxt = 4'd0;
          end else begin
            beep_cnt_nxt = beep_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, digit and registered-output update; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sec_on   <= 4'd0;
      sec_t    <= 4'd0;
      min      <= 4'd0;
      beep_cnt <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
      beep     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sec_on   <= sec_on_nxt;
      sec_t    <= sec_t_nxt;
      min      <= min_nxt;
      beep_cnt <= beep_cnt_nxt;
      running  <= (state_nxt == S_RUN);
      done     <= (state_nxt == S_DONE) && (state != S_DONE);
      beep     <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_mw_countdown_timer.sv
// tb/tb_mw_countdown_timer.sv - self-checking bench for mw_countdown_timer (optional macro MW_QUICK_START_EN)
module tb_mw_countdown_timer;

  localparam int BEEP_TICKS = 3;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] sec_on;
  logic [3:0] sec_t;
  logic [3:0] min;
  logic       running;
  logic       done;
  logic       beep;

  int tests = 0;
  int fails = 0;

  mw_countdown_timer #(.BEEP_TICKS(BEEP_TICKS)) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .start(start),
    .stop_clear(stop_clear),
    .door_closed(door_closed),
    .sec_on(sec_on),
    .sec_t(sec_t),
    .min(min),
    .running(running),
    .done(done),
    .beep(beep)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as plain digits, arithmetic done in total seconds
  int m_min = 0;
  int m_st = 0;
  int m_so = 0;
  int m_state = M_IDLE;
  int m_cnt = 0;
  bit m_done = 1'b0;

  function automatic int total_secs(input int mm, input int st, input int so);
    return mm * 60 + st * 10 + so;
  endfunction

  task automatic set_secs(input int t);
    m_min = t / 60;
    m_st  = (t % 60) / 10;
    m_so  = t % 10;
  endtask

  initial begin
    int t;
    forever begin
      @(posedge clk);
      m_done = 1'b0;
      t = total_secs(m_min, m_st, m_so);
      if (rst) begin
        m_state = M_IDLE;
        set_secs(0);
        m_cnt = 0;
      end else begin
        case (m_state)
          M_IDLE: begin
            if (stop_clear) begin
              set_secs(0);
            end else if (start && door_closed && t != 0) begin
              set_secs((t > 599) ? 599 : t);
              m_state = M_RUN;
`ifdef MW_QUICK_START_EN
            end else if (start && door_closed) begin
              set_secs(30);
              m_state = M_RUN;
`endif
            end else if (key_valid && key_digit < 4'd10) begin
              m_min = m_st;
              m_st  = m_so;
              m_so  = int'(key_digit);
            end
          end
          M_RUN: begin
            if (stop_clear || !door_closed) begin
              m_state = M_PAUSE;
`ifdef MW_QUICK_START_EN
            end else if (start) begin
              set_secs((t + 30 > 599) ? 599 : t + 30);
`endif
            end else if (tick_1hz) begin
              set_secs(t - 1);
              if (t - 1 == 0) begin
                m_state = M_DONE;
                m_done  = 1'b1;
                m_cnt   = 0;
              end
            end
          end
          M_PAUSE: begin
            if (stop_clear) begin
              m_state = M_IDLE;
              set_secs(0);
            end else if (start && door_closed) begin
              m_state = M_RUN;
            end
          end
          default: begin
            if (stop_clear || key_valid) begin
              m_state = M_IDLE;
              m_cnt = 0;
            end else if (tick_1hz) begin
              m_cnt = m_cnt + 1;
              if (m_cnt == BEEP_TICKS) begin
                m_state = M_IDLE;
                m_cnt = 0;
              end
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of every registered output against the model
  initial begin
    logic [14:0] act;
    logic [14:0] exp;
    forever begin
      @(posedge clk);
      #1;
      act = {min, sec_t, sec_on, running, done, beep};
      exp = {4'(m_min), 4'(m_st), 4'(m_so), (m_state == M_RUN), m_done, (m_state == M_DONE)};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model_cycle t=%0t got %0d:%0d%0d run=%0b done=%0b beep=%0b want %0d:%0d%0d run=%0b done=%0b beep=%0b",
                 $time, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                 exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  end

  // Hand-computed literal expectation, sampled at the falling edge
  task automatic check_lit(input string name, input int e_min, input int e_st, input int e_so,
                           input bit e_run, input bit e_done, input bit e_beep);
    logic [14:0] act;
    logic [14:0] exp;
    act = {min, sec_t, sec_on, running, done, beep};
    exp = {4'(e_min), 4'(e_st), 4'(e_so), e_run, e_done, e_beep};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d:%0d%0d run=%0b done=%0b beep=%0b want %0d:%0d%0d run=%0b done=%0b beep=%0b",
               name, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
               e_min, e_st, e_so, e_run, e_done, e_beep);
    end
  endtask

  // One clock of stimulus: strobes are applied for exactly one rising edge
  task automatic drive(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sc, input logic tk);
    key_valid  = kv;
    key_digit  = kd;
    start      = st;
    stop_clear = sc;
    tick_1hz   = tk;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic key(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_clear();
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_lit("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Entry and countdown
    key(4'd1); key(4'd3); key(4'd0);
    check_lit("entry_130", 1, 3, 0, 0, 0, 0);
    press_start();
    check_lit("start_130", 1, 3, 0, 1, 0, 0);
    ticks(11);
    check_lit("count_119", 1, 1, 9, 1, 0, 0);

    // Clear path
    press_clear();
    check_lit("pause_119", 1, 1, 9, 0, 0, 0);
    press_clear();
    check_lit("clear_idle", 0, 0, 0, 0, 0, 0);
    key(4'd12);
    check_lit("key12_ignored", 0, 0, 0, 0, 0, 0);
    key(4'd4); key(4'd11);
    check_lit("key11_ignored", 0, 0, 4, 0, 0, 0);
    press_clear();

    // Normalize and finish with beep window
    key(4'd7); key(4'd5);
    check_lit("entry_075", 0, 7, 5, 0, 0, 0);
    press_start();
    check_lit("norm_115", 1, 1, 5, 1, 0, 0);
    ticks(74);
    check_lit("at_001", 0, 0, 1, 1, 0, 0);
    ticks(1);
    check_lit("done_pulse", 0, 0, 0, 0, 1, 1);
    idle(1);
    check_lit("done_drop", 0, 0, 0, 0, 0, 1);
    ticks(2);
    check_lit("beep_2", 0, 0, 0, 0, 0, 1);
    ticks(1);
    check_lit("beep_end", 0, 0, 0, 0, 0, 0);

    // Door interlock
    key(4'd4); key(4'd2); press_start();
    check_lit("run_042", 0, 4, 2, 1, 0, 0);
    door_closed = 1'b0;
    ticks(1);
    check_lit("door_pause", 0, 4, 2, 0, 0, 0);
    press_start(); idle(1);
    check_lit("door_open_start", 0, 4, 2, 0, 0, 0);
    door_closed = 1'b1;
    press_start();
    check_lit("resume_042", 0, 4, 2, 1, 0, 0);
    ticks(1);
    check_lit("resume_041", 0, 4, 1, 1, 0, 0);
    press_clear(); press_clear();

    // Reset mid-run at 3:07; start with same-cycle tick does not decrement
    key(4'd3); key(4'd0); key(4'd7);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    check_lit("start_tick_307", 3, 0, 7, 1, 0, 0);
    rst = 1'b1;
    idle(1);
    check_lit("rst_mid_run", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle(1);

    // Saturation on entry
    key(4'd9); key(4'd7); key(4'd5); press_start();
    check_lit("sat_959", 9, 5, 9, 1, 0, 0);
    press_clear(); press_clear();

    // Key press cuts the DONE beep short and is not shifted in
    key(4'd2); press_start(); ticks(2);
    check_lit("done_002", 0, 0, 0, 0, 1, 1);
    key(4'd5);
    check_lit("done_key_exit", 0, 0, 0, 0, 0, 0);
    idle(1);

    // Quick start behaviour (or its absence)
    press_start();
`ifdef MW_QUICK_START_EN
    check_lit("qs_zero", 0, 3, 0, 1, 0, 0);
`else
    check_lit("qs_zero", 0, 0, 0, 0, 0, 0);
`endif
    press_clear(); press_clear();
    key(4'd9); key(4'd4); key(4'd5); press_start();
    press_start();
`ifdef MW_QUICK_START_EN
    check_lit("qs_945", 9, 5, 9, 1, 0, 0);
`else
    check_lit("qs_945", 9, 4, 5, 1, 0, 0);
`endif
    press_clear(); press_clear();
    key(4'd4); key(4'd5); press_start();
    press_start();
`ifdef MW_QUICK_START_EN
    check_lit("qs_045", 1, 1, 5, 1, 0, 0);
`else
    check_lit("qs_045", 0, 4, 5, 1, 0, 0);
`endif
    press_clear(); press_clear();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
